// File: rtl/alu_rs_pkg.sv
// Shared types and constants for the ALU reservation station:
// entry layout, dispatch payload and the CDB tag-match helper.
package alu_rs_pkg;

  localparam int RS_BIT  = 3;
  localparam int RS_SIZE = 2 ** RS_BIT;
  localparam int ROB_BIT = 4;

  localparam logic [6:0] OP_ARITH_I = 7'b0010011;
  localparam logic [6:0] OP_ARITH_R = 7'b0110011;
  localparam logic [6:0] OP_BRANCH  = 7'b1100011;

  typedef struct packed {
    logic               busy;
    logic [2:0]         op;
    logic [6:0]         op_type;
    logic               op_addition;
    logic [31:0]        vi;
    logic [31:0]        vj;
    logic               qi_valid;
    logic [ROB_BIT-1:0] qi;
    logic               qj_valid;
    logic [ROB_BIT-1:0] qj;
    logic [ROB_BIT-1:0] rob;
  } rs_entry_t;

  typedef struct packed {
    logic [2:0]         op;
    logic [6:0]         op_type;
    logic               op_addition;
    logic [31:0]        vi;
    logic [31:0]        vj;
    logic [ROB_BIT-1:0] rob;
  } alu_req_t;

  // Returns {hit, value}; the ALU bus wins if both buses carry the same tag.
  function automatic logic [32:0] cdb_lookup(
    input logic               alu_v,
    input logic [ROB_BIT-1:0] alu_tag,
    input logic [31:0]        alu_val,
    input logic               lsb_v,
    input logic [ROB_BIT-1:0] lsb_tag,
    input logic [31:0]        lsb_val,
    input logic [ROB_BIT-1:0] q
  );
    logic [32:0] res;
    res = {1'b0, 32'h0000_0000};
    if (alu_v && (alu_tag == q)) begin
      res = {1'b1, alu_val};
    end else if (lsb_v && (lsb_tag == q)) begin
      res = {1'b1, lsb_val};
    end else begin
      res = {1'b0, 32'h0000_0000};
    end
    return res;
  endfunction

endpackage

// File: rtl/alu_rs_if.sv
// Issue, CDB and ALU-dispatch bundle of the ALU reservation station.
// master = issue stage / CDB / ALU side, slave = the reservation station.
interface alu_rs_if;
  import alu_rs_pkg::*;

  logic               issue_valid;
  logic [2:0]         issue_op;
  logic [6:0]         issue_op_type;
  logic               issue_op_addition;
  logic [31:0]        issue_vi;
  logic [31:0]        issue_vj;
  logic               issue_qi_valid;
  logic               issue_qj_valid;
  logic [ROB_BIT-1:0] issue_qi;
  logic [ROB_BIT-1:0] issue_qj;
  logic [ROB_BIT-1:0] issue_rob_entry;
  logic               full;

  logic               alu_cdb_valid;
  logic [ROB_BIT-1:0] alu_cdb_rob;
  logic [31:0]        alu_cdb_value;
  logic               lsb_cdb_valid;
  logic [ROB_BIT-1:0] lsb_cdb_rob;
  logic [31:0]        lsb_cdb_value;

  logic               alu_valid;
  logic [31:0]        alu_vi;
  logic [31:0]        alu_vj;
  logic [2:0]         alu_op;
  logic [6:0]         alu_op_type;
  logic               alu_op_addition;
  logic [ROB_BIT-1:0] alu_rob_entry;

  modport master (
    output issue_valid, issue_op, issue_op_type, issue_op_addition,
           issue_vi, issue_vj, issue_qi_valid, issue_qj_valid,
           issue_qi, issue_qj, issue_rob_entry,
           alu_cdb_valid, alu_cdb_rob, alu_cdb_value,
           lsb_cdb_valid, lsb_cdb_rob, lsb_cdb_value,
    input  full, alu_valid, alu_vi, alu_vj, alu_op, alu_op_type,
           alu_op_addition, alu_rob_entry
  );

  modport slave (
    input  issue_valid, issue_op, issue_op_type, issue_op_addition,
           issue_vi, issue_vj, issue_qi_valid, issue_qj_valid,
           issue_qi, issue_qj, issue_rob_entry,
           alu_cdb_valid, alu_cdb_rob, alu_cdb_value,
           lsb_cdb_valid, lsb_cdb_rob, lsb_cdb_value,
    output full, alu_valid, alu_vi, alu_vj, alu_op, alu_op_type,
           alu_op_addition, alu_rob_entry
  );

endinterface

// File: rtl/alu_rs_pick.sv
// Lowest-set-bit finder: index of the least significant 1 in vec, plus a found flag.
module alu_rs_pick #(
  parameter int W     = 8,
  parameter int IDX_W = $clog2(W)
) (
  input  logic [W-1:0]     vec,
  output logic [IDX_W-1:0] idx,
  output logic             found
);

  // Scan from the top so the lowest set bit is the last one written.
  always_comb begin
    idx   = {IDX_W{1'b0}};
    found = |vec;
    for (int i = W - 1; i >= 0; i--) begin
      idx = vec[i] ? IDX_W'(i) : idx;
    end
  end

endmodule

// File: rtl/alu_rs.sv
// Reservation station for the integer ALU: holds instructions until both
// operands are known (at issue or via CDB wakeup) and dispatches one per cycle.
module alu_rs
  import alu_rs_pkg::*;
(
  input  logic     clk_in,
  input  logic     rst_in,
  input  logic     rdy_in,
  input  logic     flush,
  alu_rs_if.slave  rs
);

  rs_entry_t [RS_SIZE-1:0] entries_r;
  rs_entry_t [RS_SIZE-1:0] entries_n_s;
  rs_entry_t               new_entry_s;
  rs_entry_t               disp_s;
  alu_req_t                alu_req_r;
  logic                    alu_valid_r;

  logic [RS_SIZE-1:0] busy_vec_s;
  logic [RS_SIZE-1:0] ready_vec_s;
  logic [RS_BIT-1:0]  free_idx_s;
  logic [RS_BIT-1:0]  ready_idx_s;
  logic               free_found_s;
  logic               ready_found_s;
  logic               full_s;
  logic               issue_ok_s;
  logic [32:0]        fwd_i_s;
  logic [32:0]        fwd_j_s;
  logic [32:0]        wake_i_s;
  logic [32:0]        wake_j_s;

  // Busy and ready masks, taken from registered state only.
  always_comb begin
    busy_vec_s  = {RS_SIZE{1'b0}};
    ready_vec_s = {RS_SIZE{1'b0}};
    for (int i = 0; i < RS_SIZE; i++) begin
      busy_vec_s[i]  = entries_r[i].busy;
      ready_vec_s[i] = entries_r[i].busy && !entries_r[i].qi_valid && !entries_r[i].qj_valid;
    end
  end

  alu_rs_pick #(.W(RS_SIZE)) u_free_pick (
    .vec   (~busy_vec_s),
    .idx   (free_idx_s),
    .found (free_found_s)
  );

  alu_rs_pick #(.W(RS_SIZE)) u_ready_pick (
    .vec   (ready_vec_s),
    .idx   (ready_idx_s),
    .found (ready_found_s)
  );

  // Conservative full flag: a slot freed by this edge's dispatch is not offered.
  assign full_s     = &busy_vec_s;
  assign issue_ok_s = rs.issue_valid && !full_s && free_found_s;
  assign disp_s     = entries_r[ready_idx_s];

  // New entry, with same-cycle operand forwarding from either CDB.
  always_comb begin
    new_entry_s = '0;
    fwd_i_s = cdb_lookup(rs.alu_cdb_valid, rs.alu_cdb_rob, rs.alu_cdb_value,
                         rs.lsb_cdb_valid, rs.lsb_cdb_rob, rs.lsb_cdb_value, rs.issue_qi);
    fwd_j_s = cdb_lookup(rs.alu_cdb_valid, rs.alu_cdb_rob, rs.alu_cdb_value,
                         rs.lsb_cdb_valid, rs.lsb_cdb_rob, rs.lsb_cdb_value, rs.issue_qj);
    new_entry_s.busy        = 1'b1;
    new_entry_s.op          = rs.issue_op;
    new_entry_s.op_type     = rs.issue_op_type;
    new_entry_s.op_addition = rs.issue_op_addition;
    new_entry_s.qi          = rs.issue_qi;
    new_entry_s.qj          = rs.issue_qj;
    new_entry_s.rob         = rs.issue_rob_entry;
    if (rs.issue_qi_valid && fwd_i_s[32]) begin
      new_entry_s.vi       = fwd_i_s[31:0];
      new_entry_s.qi_valid = 1'b0;
    end else begin
      new_entry_s.vi       = rs.issue_vi;
      new_entry_s.qi_valid = rs.issue_qi_valid;
    end
    if (rs.issue_qj_valid && fwd_j_s[32]) begin
      new_entry_s.vj       = fwd_j_s[31:0];
      new_entry_s.qj_valid = 1'b0;
    end else begin
      new_entry_s.vj       = rs.issue_vj;
      new_entry_s.qj_valid = rs.issue_qj_valid;
    end
  end

  // Next entry state: wakeup, then dispatch release, then issue write.
  always_comb begin
    entries_n_s = entries_r;
    wake_i_s    = {1'b0, 32'h0000_0000};
    wake_j_s    = {1'b0, 32'h0000_0000};
    for (int i = 0; i < RS_SIZE; i++) begin
      wake_i_s = cdb_lookup(rs.alu_cdb_valid, rs.alu_cdb_rob, rs.alu_cdb_value,
                            rs.lsb_cdb_valid, rs.lsb_cdb_rob, rs.lsb_cdb_value, entries_r[i].qi);
      wake_j_s = cdb_lookup(rs.alu_cdb_valid, rs.alu_cdb_rob, rs.alu_cdb_value,
                            rs.lsb_cdb_valid, rs.lsb_cdb_rob, rs.lsb_cdb_value, entries_r[i].qj);
      if (entries_r[i].busy && entries_r[i].qi_valid && wake_i_s[32]) begin
        entries_n_s[i].vi       = wake_i_s[31:0];
        entries_n_s[i].qi_valid = 1'b0;
      end else begin
        entries_n_s[i].vi       = entries_r[i].vi;
      end
      if (entries_r[i].busy && entries_r[i].qj_valid && wake_j_s[32]) begin
        entries_n_s[i].vj       = wake_j_s[31:0];
        entries_n_s[i].qj_valid = 1'b0;
      end else begin
        entries_n_s[i].vj       = entries_r[i].vj;
      end
    end
    if (ready_found_s) begin
      entries_n_s[ready_idx_s].busy = 1'b0;
    end else begin
      entries_n_s[ready_idx_s].busy = entries_n_s[ready_idx_s].busy;
    end
    if (issue_ok_s) begin
      entries_n_s[free_idx_s] = new_entry_s;
    end else begin
      entries_n_s[free_idx_s] = entries_n_s[free_idx_s];
    end
  end

  // State and dispatch registers; rdy_in low freezes everything.
  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      entries_r   <= '0;
      alu_valid_r <= 1'b0;
      alu_req_r   <= '0;
    end else if (rdy_in) begin
      if (flush) begin
        for (int i = 0; i < RS_SIZE; i++) begin
          entries_r[i].busy <= 1'b0;
        end
        alu_valid_r <= 1'b0;
      end else begin
        entries_r   <= entries_n_s;
        alu_valid_r <= ready_found_s;
        if (ready_found_s) begin
          alu_req_r.op          <= disp_s.op;
          alu_req_r.op_type     <= disp_s.op_type;
          alu_req_r.op_addition <= disp_s.op_addition;
          alu_req_r.vi          <= disp_s.vi;
          alu_req_r.vj          <= disp_s.vj;
          alu_req_r.rob         <= disp_s.rob;
        end
      end
    end
  end

  assign rs.full            = full_s;
  assign rs.alu_valid       = alu_valid_r;
  assign rs.alu_vi          = alu_req_r.vi;
  assign rs.alu_vj          = alu_req_r.vj;
  assign rs.alu_op          = alu_req_r.op;
  assign rs.alu_op_type     = alu_req_r.op_type;
  assign rs.alu_op_addition = alu_req_r.op_addition;
  assign rs.alu_rob_entry   = alu_req_r.rob;

endmodule

// File: tb/tb_alu_rs.sv
// Directed self-checking bench for alu_rs: issue, forwarding, wakeup, full,
// ordering, rdy_in stall, flush and asynchronous reset.
module tb_alu_rs;
  import alu_rs_pkg::*;

  logic clk_in = 1'b0;
  logic rst_in;
  logic rdy_in;
  logic flush;
  int   checks = 0;
  int   failures = 0;

  alu_rs_if bus ();

  alu_rs dut (
    .clk_in (clk_in),
    .rst_in (rst_in),
    .rdy_in (rdy_in),
    .flush  (flush),
    .rs     (bus.slave)
  );

  always #5 clk_in = ~clk_in;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk_in);
    #1;
  endtask

  task automatic idle();
    bus.issue_valid   = 1'b0;
    bus.alu_cdb_valid = 1'b0;
    bus.lsb_cdb_valid = 1'b0;
  endtask

  task automatic issue(input logic [6:0] op_type, input logic [2:0] op, input logic add,
                       input logic [31:0] vi, input logic [31:0] vj,
                       input logic qiv, input logic [ROB_BIT-1:0] qi,
                       input logic qjv, input logic [ROB_BIT-1:0] qj,
                       input logic [ROB_BIT-1:0] rob);
    bus.issue_valid       = 1'b1;
    bus.issue_op_type     = op_type;
    bus.issue_op          = op;
    bus.issue_op_addition = add;
    bus.issue_vi          = vi;
    bus.issue_vj          = vj;
    bus.issue_qi_valid    = qiv;
    bus.issue_qi          = qi;
    bus.issue_qj_valid    = qjv;
    bus.issue_qj          = qj;
    bus.issue_rob_entry   = rob;
  endtask

  initial begin
    rst_in = 1'b1;
    rdy_in = 1'b1;
    flush  = 1'b0;
    issue(OP_ARITH_I, 3'd0, 1'b0, 32'd0, 32'd0, 1'b0, 4'd0, 1'b0, 4'd0, 4'd0);
    idle();
    bus.alu_cdb_rob   = 4'd0;
    bus.alu_cdb_value = 32'd0;
    bus.lsb_cdb_rob   = 4'd0;
    bus.lsb_cdb_value = 32'd0;
    tick();
    tick();
    check("rst_alu_valid", bus.alu_valid, 1'b0);
    check("rst_full", bus.full, 1'b0);
    check("rst_alu_vi", bus.alu_vi, 32'd0);
    check("rst_alu_rob", bus.alu_rob_entry, 4'd0);
    check("rst_alu_op_type", bus.alu_op_type, 7'd0);
    rst_in = 1'b0;
    tick();

    // ADD, both operands ready
    issue(OP_ARITH_R, 3'd0, 1'b0, 32'd5, 32'd7, 1'b0, 4'd0, 1'b0, 4'd0, 4'd3);
    tick();
    idle();
    check("add_latency", bus.alu_valid, 1'b0);
    tick();
    check("add_valid", bus.alu_valid, 1'b1);
    check("add_vi", bus.alu_vi, 32'd5);
    check("add_vj", bus.alu_vj, 32'd7);
    check("add_rob", bus.alu_rob_entry, 4'd3);
    check("add_type", bus.alu_op_type, OP_ARITH_R);
    tick();
    check("add_done", bus.alu_valid, 1'b0);
    check("add_hold_vi", bus.alu_vi, 32'd5);

    // SUB waiting on tag 2 from the LSB bus
    issue(OP_ARITH_R, 3'd0, 1'b1, 32'd0, 32'd1, 1'b1, 4'd2, 1'b0, 4'd0, 4'd5);
    tick();
    idle();
    for (int k = 0; k < 3; k++) begin
      tick();
      check("sub_wait", bus.alu_valid, 1'b0);
    end
    bus.lsb_cdb_valid = 1'b1;
    bus.lsb_cdb_rob   = 4'd2;
    bus.lsb_cdb_value = 32'h10;
    tick();
    idle();
    check("sub_wake_edge", bus.alu_valid, 1'b0);
    tick();
    check("sub_valid", bus.alu_valid, 1'b1);
    check("sub_vi", bus.alu_vi, 32'h10);
    check("sub_vj", bus.alu_vj, 32'd1);
    check("sub_add", bus.alu_op_addition, 1'b1);
    check("sub_rob", bus.alu_rob_entry, 4'd5);
    tick();

    // Same-cycle forwarding of qj from the ALU bus
    issue(OP_BRANCH, 3'd1, 1'b0, 32'd3, 32'd0, 1'b0, 4'd0, 1'b1, 4'd4, 4'd7);
    bus.alu_cdb_valid = 1'b1;
    bus.alu_cdb_rob   = 4'd4;
    bus.alu_cdb_value = 32'd9;
    tick();
    idle();
    tick();
    check("fwd_valid", bus.alu_valid, 1'b1);
    check("fwd_vj", bus.alu_vj, 32'd9);
    check("fwd_vi", bus.alu_vi, 32'd3);
    check("fwd_op", bus.alu_op, 3'd1);
    check("fwd_type", bus.alu_op_type, OP_BRANCH);
    tick();

    // Fill every slot waiting on tag 6
    for (int k = 0; k < RS_SIZE; k++) begin
      issue(OP_ARITH_I, 3'd0, 1'b0, 32'd0, 32'(k), 1'b1, 4'd6, 1'b0, 4'd0, 4'(k));
      tick();
    end
    check("fill_full", bus.full, 1'b1);
    issue(OP_ARITH_R, 3'd0, 1'b0, 32'hDEAD, 32'd0, 1'b0, 4'd0, 1'b0, 4'd0, 4'd15);
    tick();
    idle();
    check("drop_full", bus.full, 1'b1);
    check("drop_no_disp", bus.alu_valid, 1'b0);
    bus.alu_cdb_valid = 1'b1;
    bus.alu_cdb_rob   = 4'd6;
    bus.alu_cdb_value = 32'h66;
    tick();
    idle();
    check("wake_still_full", bus.full, 1'b1);
    for (int k = 0; k < RS_SIZE; k++) begin
      tick();
      check("burst_valid", bus.alu_valid, 1'b1);
      check("burst_rob", bus.alu_rob_entry, 4'(k));
      check("burst_vi", bus.alu_vi, 32'h66);
      check("burst_vj", bus.alu_vj, 32'(k));
      if (k == 0) check("burst_full_drop", bus.full, 1'b0);
    end
    tick();
    check("burst_end", bus.alu_valid, 1'b0);

    // Slots 1 and 5 become ready together; the rest wait on tag 9
    for (int k = 0; k < 6; k++) begin
      issue(OP_ARITH_R, 3'd2, 1'b0, 32'd0, 32'd0, 1'b1,
            (k == 1 || k == 5) ? 4'd10 : 4'd9, 1'b0, 4'd0, 4'(8 + k));
      tick();
    end
    idle();
    bus.lsb_cdb_valid = 1'b1;
    bus.lsb_cdb_rob   = 4'd10;
    bus.lsb_cdb_value = 32'h20;
    tick();
    idle();
    tick();
    check("order_first", bus.alu_rob_entry, 4'd9);
    check("order_first_v", bus.alu_valid, 1'b1);
    rdy_in = 1'b0;
    bus.alu_cdb_valid = 1'b1;
    bus.alu_cdb_rob   = 4'd9;
    bus.alu_cdb_value = 32'h99;
    for (int k = 0; k < 3; k++) begin
      tick();
      check("stall_valid", bus.alu_valid, 1'b1);
      check("stall_rob", bus.alu_rob_entry, 4'd9);
    end
    rdy_in = 1'b1;
    idle();
    tick();
    check("order_second", bus.alu_rob_entry, 4'd13);
    check("order_second_v", bus.alu_valid, 1'b1);
    check("order_second_vi", bus.alu_vi, 32'h20);
    tick();
    check("stall_cdb_ignored", bus.alu_valid, 1'b0);

    // Flush with four waiting entries and a dispatch in flight
    issue(OP_ARITH_R, 3'd0, 1'b0, 32'd1, 32'd1, 1'b0, 4'd0, 1'b0, 4'd0, 4'd14);
    tick();
    idle();
    tick();
    check("pre_flush_valid", bus.alu_valid, 1'b1);
    check("pre_flush_rob", bus.alu_rob_entry, 4'd14);
    flush = 1'b1;
    bus.alu_cdb_valid = 1'b1;
    bus.alu_cdb_rob   = 4'd9;
    bus.alu_cdb_value = 32'h99;
    tick();
    flush = 1'b0;
    check("flush_valid", bus.alu_valid, 1'b0);
    check("flush_full", bus.full, 1'b0);
    tick();
    idle();
    for (int k = 0; k < 3; k++) begin
      tick();
      check("flush_quiet", bus.alu_valid, 1'b0);
    end
    issue(OP_ARITH_I, 3'd4, 1'b0, 32'h77, 32'd2, 1'b0, 4'd0, 1'b0, 4'd0, 4'd2);
    tick();
    idle();
    tick();
    check("post_flush_valid", bus.alu_valid, 1'b1);
    check("post_flush_vi", bus.alu_vi, 32'h77);
    check("post_flush_op", bus.alu_op, 3'd4);
    tick();

    // Asynchronous reset mid-stream drops a waiting entry
    issue(OP_ARITH_R, 3'd0, 1'b0, 32'd0, 32'd0, 1'b1, 4'd12, 1'b0, 4'd0, 4'd1);
    tick();
    issue(OP_ARITH_R, 3'd0, 1'b0, 32'h55, 32'd0, 1'b0, 4'd0, 1'b0, 4'd0, 4'd4);
    tick();
    idle();
    tick();
    check("arst_pre_valid", bus.alu_valid, 1'b1);
    #2;
    rst_in = 1'b1;
    #1;
    check("arst_valid", bus.alu_valid, 1'b0);
    check("arst_vi", bus.alu_vi, 32'd0);
    tick();
    rst_in = 1'b0;
    bus.alu_cdb_valid = 1'b1;
    bus.alu_cdb_rob   = 4'd12;
    bus.alu_cdb_value = 32'h12;
    tick();
    idle();
    tick();
    check("arst_discard", bus.alu_valid, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
